// File: rtl/primos_pkg.sv
// Shared types and constants for the 4-bit prime range scanner.
package primos_pkg;
    localparam int LARGURA = 4;
    localparam logic [15:0] MASCARA_PRIMOS_4B = 16'h28AC;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        VARRE  = 2'd1,
        FIM    = 2'd2
    } estado_t;
endpackage

// File: rtl/primo.sv
// Combinational 4-bit prime detector: F=1 iff N is one of 2,3,5,7,11,13.
module primo
    import primos_pkg::*;
(
    input  logic [LARGURA-1:0] N,
    output logic               F
);
    assign F = MASCARA_PRIMOS_4B[N];
endmodule

// File: rtl/varredura_primos.sv
// Range scanner: presents lo..hi to primo one per clock and gathers a prime mask and count.
module varredura_primos
    import primos_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [LARGURA-1:0] lo,
    input  logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] N,
    output logic               busy,
    output logic               done,
    output logic               erro,
    output logic [15:0]        mascara,
    output logic [4:0]         contagem
);
    estado_t            estado;
    logic [LARGURA-1:0] hi_r;
    logic               f;

    primo u_primo (
        .N(N),
        .F(f)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= OCIOSO;
            N        <= '0;
            hi_r     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            erro     <= 1'b0;
            mascara  <= '0;
            contagem <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    done <= 1'b0;
                    if (start) begin
                        hi_r     <= hi;
                        mascara  <= '0;
                        contagem <= '0;
                        busy     <= 1'b1;
                        if (lo <= hi) begin
                            N      <= lo;
                            erro   <= 1'b0;
                            estado <= VARRE;
                        end else begin
                            // Empty range: skip straight to completion.
                            erro   <= 1'b1;
                            done   <= 1'b1;
                            estado <= FIM;
                        end
                    end
                end
                VARRE: begin
                    mascara[N] <= f;
                    contagem   <= contagem + {4'd0, f};
                    // End test precedes the increment so hi=15 never wraps N.
                    if (N == hi_r) begin
                        done   <= 1'b1;
                        estado <= FIM;
                    end else begin
                        N <= N + 1'b1;
                    end
                end
                FIM: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    estado <= OCIOSO;
                end
                default: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    estado <= OCIOSO;
                end
            endcase
        end
    end
endmodule

// File: doc/varredura_primos.md
# varredura_primos

Sequential range scanner that sits directly upstream of the 4-bit combinational prime detector `primo`. On a start request it drives `primo` with every value from `lo` to `hi`, one per clock. It registers each `F` result into a 16-bit prime mask and a prime count, then reports completion with a one-cycle `done` pulse. It turns the per-value detector into a handshaked block that answers which values in a range are prime and how many there are.

## Interface
- Parameters: none. Width is fixed at 4 bits to match `primo`.
- `clock`  in  1  single system clock, rising-edge active
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  scan request, sampled only in OCIOSO
- `lo`  in  4  first value of the range, captured on accepted `start`
- `hi`  in  4  last value of the range, captured on accepted `start`
- `N`  out  4  value currently presented to `primo`
- `busy`  out  1  high in VARRE and FIM
- `done`  out  1  one-cycle pulse in FIM
- `erro`  out  1  set when the captured `lo > hi`; held until the next accepted start
- `mascara`  out  16  bit k = 1 iff k was scanned and is prime
- `contagem`  out  5  number of primes found in the range

## Operation
- FSM states: OCIOSO, VARRE, FIM.
- OCIOSO:
  - When `start`=1, capture `lo`/`hi`, clear `mascara`, `contagem` and `erro`.
  - If `lo <= hi`: load `N <= lo`, go to VARRE.
  - Otherwise: set `erro`, go straight to FIM.
- VARRE, each cycle:
  - `mascara[N] <= F`.
  - `contagem <= contagem + F`.
  - If `N == hi`, go to FIM and hold `N`. Otherwise `N <= N + 1`.
- FIM: `done`=1 for exactly one cycle, then go to OCIOSO.
- Results (`mascara`, `contagem`, `erro`, `N`) hold their values in OCIOSO until the next accepted start.
- `start` is ignored while `busy`=1. No queuing.
- Wrap-around: the end test is `N == hi`, evaluated before incrementing. With `hi=15`, `N` never wraps to 0.
- Arithmetic: `contagem` is 5 bits. Its maximum is 6 for 4-bit inputs, so overflow is impossible.
- Reset (asynchronous, at any time, including mid-scan):
  - State returns to OCIOSO.
  - `N`=0, `busy`=0, `done`=0, `erro`=0, `mascara`=0, `contagem`=0.
  - Any partial results are discarded.

## Timing
- Let edge k be the edge that accepts `start`.
- Normal range:
  - VARRE occupies edges k+1 through k+L, where L = hi−lo+1.
  - FIM is the cycle after edge k+L; `done` is high there.
  - Total latency from start to `done` is L+1 cycles.
- `lo > hi`: `done` is high in the cycle right after edge k.
- `primo` is purely combinational, so `F` is valid in the same cycle `N` is presented. There are no extra pipeline stages.
- `busy` rises at edge k and falls at the edge that leaves FIM.
- `start` held high through FIM is honoured at the first OCIOSO cycle after FIM. There is no back-to-back acceptance in FIM itself.

## Structure
- Package `primos_pkg`:
  - state enum `estado_t` (OCIOSO, VARRE, FIM)
  - constant `MASCARA_PRIMOS_4B = 16'h28AC`, used as the bench golden value
  - constant `LARGURA = 4`
- Sub-module: one instance of the existing combinational `primo` (`N` in, `F` out), instantiated inside this block.
- Sequential logic:
  - one FSM register
  - registers for `N`, `hi`, `mascara`, `contagem`, `erro`

## Test plan
- `lo=0`, `hi=15`, pulse `start`:
  - `mascara`=16'h28AC, `contagem`=6, `erro`=0.
  - `done` high exactly 17 cycles after the accepting edge.
- `lo=8`, `hi=10`: `mascara`=0, `contagem`=0, `done` after 4 cycles.
- `lo=hi=13`: `mascara`=16'h2000, `contagem`=1, `done` after 2 cycles. `N` holds at 13 after completion.
- `lo=9`, `hi=4`: `erro`=1, `mascara`=0, `contagem`=0, `done` in the next cycle.
- `start` pulsed with new `lo`/`hi` while `busy`=1: ignored. The original range's results and timing are unchanged.
- Assert `reset_n`=0 asynchronously at mid-scan of 0..15:
  - All outputs go to 0 immediately.
  - After release, a new scan 2..3 yields `mascara`=16'h000C, `contagem`=2.
